// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: merges a read and a write requester onto one 1RW array port via a one-entry write buffer
//   clock/reset_n                      : rising-edge clock, async active-low reset
//   rreq_valid/rreq_ready/rreq_addr    : read request channel
//   rresp_valid/rresp_data             : read response, 1 cycle after accept, no backpressure
//   wreq_valid/wreq_ready/wreq_addr/wreq_data : write request channel
//   sram_en/wmode/addr/wmask/wdata/rdata      : array port, rdata valid the cycle after a read enable
//   idle                               : no buffered write and no response pending
module sram_1rw_arbiter #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 334,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rreq_valid,
  output logic              rreq_ready,
  input  logic [ADDR_W-1:0] rreq_addr,
  output logic              rresp_valid,
  output logic [DATA_W-1:0] rresp_data,
  input  logic              wreq_valid,
  output logic              wreq_ready,
  input  logic [ADDR_W-1:0] wreq_addr,
  input  logic [DATA_W-1:0] wreq_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              idle
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {ACT_IDLE, ACT_READ, ACT_DRAIN} act_t;
  act_t              act;
  logic              wbuf_valid;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [DATA_W-1:0] wbuf_data;
  logic [SW-1:0]     starve;
  logic              fwd_sel;
  logic [DATA_W-1:0] fwd_data;
  logic              force_drain, hit, rd_acc, wr_acc;
  always_comb begin
    force_drain = wbuf_valid && starve == SW'(STARVE_MAX);
    hit         = wbuf_valid && rreq_addr == wbuf_addr;
    rd_acc      = reset_n && rreq_valid && !force_drain;
    // a hit read never touches the array: the port commits the buffer instead and the data is forwarded
    act         = !reset_n ? ACT_IDLE :
                  (rd_acc && !hit) ? ACT_READ :
                  (rd_acc || wbuf_valid) ? ACT_DRAIN : ACT_IDLE;
    rreq_ready  = !force_drain;
    wreq_ready  = !wbuf_valid || act == ACT_DRAIN;
    wr_acc      = wreq_valid && wreq_ready;
    sram_en     = act != ACT_IDLE;
    sram_wmode  = act == ACT_DRAIN;
    sram_wmask  = act == ACT_DRAIN;
    sram_addr   = (act == ACT_READ) ? rreq_addr : (act == ACT_DRAIN) ? wbuf_addr : '0;
    sram_wdata  = (act == ACT_DRAIN) ? wbuf_data : '0;
    rresp_data  = fwd_sel ? fwd_data : sram_rdata;
    idle        = !wbuf_valid && !rresp_valid;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wbuf_valid  <= 1'b0;
      starve      <= '0;
      rresp_valid <= 1'b0;
      fwd_sel     <= 1'b1;
      fwd_data    <= '0;
    end else begin
      wbuf_valid  <= wr_acc || (wbuf_valid && act != ACT_DRAIN);
      starve      <= (act == ACT_DRAIN) ? '0 :
                     (wbuf_valid && act == ACT_READ && starve != SW'(STARVE_MAX)) ? starve + SW'(1) : starve;
      rresp_valid <= rd_acc;
      if (rd_acc) fwd_sel <= hit;
      if (rd_acc && hit) fwd_data <= wbuf_data;
    end
  end
  // buffer payload is qualified by wbuf_valid, so it needs no reset
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      wbuf_addr <= wreq_addr;
      wbuf_data <= wreq_data;
    end
  end
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb_sram_1rw_arbiter: directed scoreboard bench for sram_1rw_arbiter with a behavioral 1RW array
module tb_sram_1rw_arbiter;
  localparam int AW = 2;
  localparam int DW = 334;
  localparam logic [DW-1:0] Z0 = '0;
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rreq_valid = 1'b0, rreq_ready;
  logic [AW-1:0] rreq_addr = '0;
  logic          rresp_valid;
  logic [DW-1:0] rresp_data;
  logic          wreq_valid = 1'b0, wreq_ready;
  logic [AW-1:0] wreq_addr = '0;
  logic [DW-1:0] wreq_data = '0;
  logic          sram_en, sram_wmode, sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          idle;
  logic [DW-1:0] mem [4];
  logic [DW-1:0] expq [$];
  int            total = 0;
  int            bad = 0;
  int            rst_en = 0;
  sram_1rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr),
    .rresp_valid(rresp_valid), .rresp_data(rresp_data),
    .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr), .wreq_data(wreq_data),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr), .sram_wmask(sram_wmask),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .idle(idle)
  );
  always #5 clock = ~clock;
  initial for (int i = 0; i < 4; i++) mem[i] = '0;
  always @(posedge clock) begin
    if (sram_en && sram_wmode) mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
    if (!reset_n && sram_en) rst_en <= rst_en + 1;
  end
  function automatic logic [DW-1:0] pat(input logic [7:0] b);
    logic [335:0] t;
    t = {42{b}};
    return t[DW-1:0];
  endfunction
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic chkb(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  always @(negedge clock) begin
    if (reset_n && rresp_valid) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rresp_unexpected: got %h want no response", rresp_data);
      end else chk("rresp_data", rresp_data, expq.pop_front());
    end
  end
  task automatic cyc(input int rv, input int ra, input int wv, input int wa, input logic [DW-1:0] wd,
                     input int e_rr, input int e_wr, input int e_en, input int e_wm, input int e_ad,
                     input logic [DW-1:0] e_wd, input logic [DW-1:0] e_rd);
    logic [31:0] rav, wav;
    rav = ra;
    wav = wa;
    rreq_valid = rv != 0;
    rreq_addr  = rav[AW-1:0];
    wreq_valid = wv != 0;
    wreq_addr  = wav[AW-1:0];
    wreq_data  = wd;
    if (rv != 0 && e_rr != 0) expq.push_back(e_rd);
    @(negedge clock);
    chkb("rreq_ready", int'(rreq_ready), e_rr);
    chkb("wreq_ready", int'(wreq_ready), e_wr);
    chkb("sram_en", int'(sram_en), e_en);
    chkb("sram_wmode", int'(sram_wmode), e_wm);
    chkb("sram_wmask", int'(sram_wmask), e_wm);
    chkb("sram_addr", int'(sram_addr), e_ad);
    if (e_wm != 0 || e_en == 0) chk("sram_wdata", sram_wdata, e_wd);
    @(posedge clock);
    #1;
  endtask
  task automatic nop;
    cyc(0, 0, 0, 0, Z0, 1, 1, 0, 0, 0, Z0, Z0);
  endtask
  initial begin
    logic [DW-1:0] pa, d, e, x, y;
    pa = pat(8'h5A);
    d  = pat(8'hC3);
    e  = pat(8'h3C);
    x  = pat(8'h11);
    y  = pat(8'h22);
    #12;
    chkb("rst_rreq_ready", int'(rreq_ready), 1);
    chkb("rst_wreq_ready", int'(wreq_ready), 1);
    chkb("rst_sram_en", int'(sram_en), 0);
    chkb("rst_idle", int'(idle), 1);
    chkb("rst_rresp_valid", int'(rresp_valid), 0);
    chk("rst_rresp_data", rresp_data, Z0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc(0, 0, 1, 2, pa, 1, 1, 0, 0, 0, Z0, Z0);
    cyc(0, 0, 0, 0, Z0, 1, 1, 1, 1, 2, pa, Z0);
    nop();
    cyc(1, 2, 0, 0, Z0, 1, 1, 1, 0, 2, Z0, pa);
    cyc(0, 0, 1, 1, d, 1, 1, 0, 0, 0, Z0, Z0);
    cyc(1, 1, 0, 0, Z0, 1, 1, 1, 1, 1, d, d);
    cyc(1, 1, 0, 0, Z0, 1, 1, 1, 0, 1, Z0, d);
    cyc(1, 1, 0, 0, Z0, 1, 1, 1, 0, 1, Z0, d);
    nop();
    cyc(0, 0, 1, 3, e, 1, 1, 0, 0, 0, Z0, Z0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, Z0, 1, 0, 1, 0, 0, Z0, Z0);
    cyc(1, 0, 0, 0, Z0, 0, 1, 1, 1, 3, e, Z0);
    cyc(1, 0, 0, 0, Z0, 1, 1, 1, 0, 0, Z0, Z0);
    nop();
    cyc(0, 0, 1, 0, x, 1, 1, 0, 0, 0, Z0, Z0);
    cyc(0, 0, 0, 0, Z0, 1, 1, 1, 1, 0, x, Z0);
    cyc(1, 0, 1, 0, y, 1, 1, 1, 0, 0, Z0, x);
    cyc(1, 0, 0, 0, Z0, 1, 1, 1, 1, 0, y, y);
    nop();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b, pb;
      int dr, pad;
      b   = 8'h40 + 8'(i);
      pb  = b - 8'h01;
      dr  = (i > 0) ? 1 : 0;
      pad = (i > 0) ? i - 1 : 0;
      cyc(0, 0, 1, i, pat(b), 1, 1, dr, dr, pad, (i > 0) ? pat(pb) : Z0, Z0);
    end
    cyc(0, 0, 0, 0, Z0, 1, 1, 1, 1, 3, pat(8'h43), Z0);
    nop();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'h40 + 8'(i);
      cyc(1, i, 0, 0, Z0, 1, 1, 1, 0, i, Z0, pat(b));
    end
    nop();
    rreq_valid = 1'b1;
    rreq_addr  = 2'd3;
    wreq_valid = 1'b1;
    wreq_addr  = 2'd2;
    wreq_data  = pat(8'h99);
    @(posedge clock);
    #1;
    rreq_valid = 1'b0;
    wreq_valid = 1'b0;
    chkb("pre_rst_idle", int'(idle), 0);
    chkb("pre_rst_rresp_valid", int'(rresp_valid), 1);
    reset_n = 1'b0;
    #1;
    chkb("mid_rst_rresp_valid", int'(rresp_valid), 0);
    chk("mid_rst_rresp_data", rresp_data, Z0);
    chkb("mid_rst_rreq_ready", int'(rreq_ready), 1);
    chkb("mid_rst_wreq_ready", int'(wreq_ready), 1);
    chkb("mid_rst_sram_en", int'(sram_en), 0);
    chkb("mid_rst_idle", int'(idle), 1);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    nop();
    nop();
    cyc(1, 2, 0, 0, Z0, 1, 1, 1, 0, 2, Z0, pat(8'h42));
    nop();
    chkb("rst_array_access", rst_en, 0);
    chk("rst_discarded_write", mem[2], pat(8'h42));
    chkb("end_idle", int'(idle), 1);
    chkb("queue_left", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
